// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the graphics/map SRAM read-port arbiter.
package sram_port_arbiter_pkg;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {
    REQ_TILE   = 2'd0,
    REQ_SPRITE = 2'd1,
    REQ_MAP    = 2'd2
  } req_id_t;

  typedef struct packed {
    logic    v;
    req_id_t id;
  } rd_tag_t;

  // One-hot requester vector for a requester id.
  function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
    return NUM_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester/memory side bundle of the SRAM read-port arbiter.
interface sram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16
);
  logic [2:0]        req;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic              mem_stall;
  logic [2:0]        gnt;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [2:0]        rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, addr0, addr1, addr2, mem_stall, mem_rdata,
    input  gnt, mem_rd, mem_addr, rvalid, rdata
  );

  modport slave (
    input  req, addr0, addr1, addr2, mem_stall, mem_rdata,
    output gnt, mem_rd, mem_addr, rvalid, rdata
  );
endinterface

// File: rtl/sram_port_arbiter_wait_counter.sv
// Saturating wait counter: counts cycles a request is pending, clears on grant or drop.
module arb_wait_counter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             gnt,
  output logic [CNT_W-1:0] count,
  output logic             starved
);

  logic [CNT_W-1:0] count_next;

  // Next count: clear on grant or dropped request, else count up to the ceiling.
  always_comb begin
    count_next = count;
    if (!req || gnt) begin
      count_next = '0;
    end else if (count != CNT_W'(STARVE_MAX)) begin
      count_next = count + CNT_W'(1);
    end
  end

  // Count and starved flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      starved <= 1'b0;
    end else begin
      count   <= count_next;
      starved <= (count_next == CNT_W'(STARVE_MAX));
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one pipelined SRAM read port between tile, sprite and map requesters.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 16
) (
  input  logic                Clk,
  input  logic                Reset_n,
  sram_port_arbiter_if.slave  bus
);

  logic             rr_q;
  logic             gnt_v;
  req_id_t          gnt_id;
  logic [2:0]       gnt_oh;
  logic [ADDR_W-1:0] gnt_addr;
  logic [CNT_W-1:0] wait1_cnt;
  logic [CNT_W-1:0] wait2_cnt;
  logic             wait1_starved;
  logic             wait2_starved;
  logic             starve1;
  logic             starve2;
  rd_tag_t          tag_q [MEM_LAT+1];

  // Counts are kept as visible debug state; only the starved flags steer arbitration.
  logic unused_cnt;
  assign unused_cnt = ^{wait1_cnt, wait2_cnt};

  arb_wait_counter #(.STARVE_MAX(STARVE_MAX)) u_wait1 (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .req     (bus.req[1]),
    .gnt     (gnt_oh[1]),
    .count   (wait1_cnt),
    .starved (wait1_starved)
  );

  arb_wait_counter #(.STARVE_MAX(STARVE_MAX)) u_wait2 (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .req     (bus.req[2]),
    .gnt     (gnt_oh[2]),
    .count   (wait2_cnt),
    .starved (wait2_starved)
  );

  // A starved flag only counts while its request is still asserted.
  assign starve1 = wait1_starved && bus.req[1];
  assign starve2 = wait2_starved && bus.req[2];

  // Grant selection: starvation override, then tile priority, then round robin.
  always_comb begin
    gnt_v  = 1'b0;
    gnt_id = REQ_TILE;
    if (Reset_n && !bus.mem_stall) begin
      if (starve1 || starve2) begin
        gnt_v = 1'b1;
        if (starve1 && starve2) gnt_id = rr_q ? REQ_MAP : REQ_SPRITE;
        else                    gnt_id = starve1 ? REQ_SPRITE : REQ_MAP;
      end else if (bus.req[0]) begin
        gnt_v  = 1'b1;
        gnt_id = REQ_TILE;
      end else if (bus.req[1] && bus.req[2]) begin
        gnt_v  = 1'b1;
        gnt_id = rr_q ? REQ_MAP : REQ_SPRITE;
      end else if (bus.req[1]) begin
        gnt_v  = 1'b1;
        gnt_id = REQ_SPRITE;
      end else if (bus.req[2]) begin
        gnt_v  = 1'b1;
        gnt_id = REQ_MAP;
      end
    end
  end

  assign gnt_oh  = gnt_v ? id_onehot(gnt_id) : 3'b000;
  assign bus.gnt = gnt_oh;

  // Address of the granted requester.
  always_comb begin
    gnt_addr = bus.addr0;
    case (gnt_id)
      REQ_SPRITE: gnt_addr = bus.addr1;
      REQ_MAP:    gnt_addr = bus.addr2;
      default:    gnt_addr = bus.addr0;
    endcase
  end

  // Round-robin pointer: after a sprite grant prefer map, after a map grant prefer sprite.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)                rr_q <= 1'b0;
    else if (gnt_oh[1])          rr_q <= 1'b1;
    else if (gnt_oh[2])          rr_q <= 1'b0;
  end

  // Memory read strobe and address registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.mem_rd   <= 1'b0;
      bus.mem_addr <= '0;
    end else begin
      bus.mem_rd <= gnt_v;
      if (gnt_v) bus.mem_addr <= gnt_addr;
    end
  end

  // Tag pipeline tracks the owner of each in-flight read; free-running so stalls keep timing.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i <= MEM_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{v: gnt_v, id: gnt_id};
      for (int unsigned i = 1; i <= MEM_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Return register: capture memory data for the owner at the end of the pipeline.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.rvalid <= '0;
      bus.rdata  <= '0;
    end else begin
      bus.rvalid <= tag_q[MEM_LAT].v ? id_onehot(tag_q[MEM_LAT].id) : 3'b000;
      if (tag_q[MEM_LAT].v) bus.rdata <= bus.mem_rdata;
    end
  end

endmodule
